// File: rtl/insn_encoder_pkg.sv
// Shared core package: encoder request kinds, error codes, ALU ops,
// tiny16 opcode constants and the packer result bundle.
// Optional feature macro: INSN_ENC_LI16_EN (two-word LI for imm > 255).
package insn_encoder_pkg;

    typedef enum logic [2:0] {
        ENC_ALU = 3'd0,
        ENC_LI  = 3'd1,
        ENC_LDR = 3'd2,
        ENC_STR = 3'd3,
        ENC_BR  = 3'd4
    } enc_kind_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_OP    = 2'd1,
        ERR_RANGE = 2'd2
    } enc_err_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    localparam logic [3:0] OP_LDLI = 4'hA;
    localparam logic [3:0] OP_LDUI = 4'hB;
    localparam logic [3:0] OP_LDR  = 4'hC;
    localparam logic [3:0] OP_STR  = 4'hD;
    localparam logic [3:0] OP_B    = 4'hE;

`ifdef INSN_ENC_LI16_EN
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_EMIT_HI = 1'b1
    } enc_state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0
    } enc_state_t;
`endif

    // Result of packing one request: first word, optional
    // second word, and the error verdict.
    typedef struct packed {
        logic [15:0] lo;
`ifdef INSN_ENC_LI16_EN
        logic [15:0] hi;
        logic        two;
`endif
        logic        err;
        enc_err_t    code;
    } pack_res_t;

endpackage

// File: rtl/insn_word_pack.sv
// Combinational packer: turns one micro-op request into tiny16 word(s)
// plus op/range error. Ports: request fields, addr of word -> res.
// Optional feature macro: INSN_ENC_LI16_EN (two-word LI).
module insn_word_pack
    import insn_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu_op,
    input  logic        use_imm,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [15:0] imm,
    input  logic [3:0]  cond,
    input  logic [15:0] target,
    input  logic [15:0] addr,
    output pack_res_t   res
);

    logic [15:0] off;
    logic        off_bad;

    // Branch offset is relative to the word after the branch;
    // it must fit a signed byte and be halfword aligned.
    always_comb begin
        off     = target - (addr + 16'd2);
        off_bad = off[0] ||
                  !((off[15:7] == 9'h000) || (off[15:7] == 9'h1FF));
    end

    always_comb begin
        res      = '0;
        res.code = ERR_NONE;
        unique case (kind)
            ENC_ALU: begin
                if (alu_op > ALU_XOR) begin
                    res.err  = 1'b1;
                    res.code = ERR_OP;
                end else if (use_imm && (imm > 16'd15)) begin
                    res.err  = 1'b1;
                    res.code = ERR_RANGE;
                end else begin
                    res.lo = {alu_op, ~use_imm, rd, rs1,
                              use_imm ? imm[3:0] : rs2};
                end
            end
            ENC_LI: begin
                res.lo = {OP_LDLI, rd, imm[7:0]};
                if (imm[15:8] != 8'h00) begin
`ifdef INSN_ENC_LI16_EN
                    res.hi  = {OP_LDUI, rd, imm[15:8]};
                    res.two = 1'b1;
`else
                    res.err  = 1'b1;
                    res.code = ERR_RANGE;
`endif
                end
            end
            ENC_LDR, ENC_STR: begin
                if (imm > 16'd15) begin
                    res.err  = 1'b1;
                    res.code = ERR_RANGE;
                end else begin
                    res.lo = {(kind == ENC_LDR) ? OP_LDR : OP_STR,
                              rd, rs1, imm[3:0]};
                end
            end
            ENC_BR: begin
                if (off_bad) begin
                    res.err  = 1'b1;
                    res.code = ERR_RANGE;
                end else begin
                    res.lo = {OP_B, cond, off[7:0]};
                end
            end
            default: begin
                res.err  = 1'b1;
                res.code = ERR_OP;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder: packs micro-op requests into tiny16 words and
// streams them to a memory write port at auto-incrementing addresses.
// Ports: clk/rst_n, start/start_addr, req_* (valid/ready request),
//   w_* (valid/ready write port), addr (next free), err/err_code (sticky).
// Optional feature macro: INSN_ENC_LI16_EN (LI imm > 255 -> two words).
module insn_encoder
    import insn_encoder_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [2:0]  req_alu_op,
    input  logic        req_use_imm,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_rs1,
    input  logic [3:0]  req_rs2,
    input  logic [15:0] req_imm,
    input  logic [3:0]  req_cond,
    input  logic [15:0] req_target,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [15:0] w_addr,
    output logic [15:0] w_data,
    output logic [15:0] addr,
    output logic        err,
    output logic [1:0]  err_code
);

    enc_state_t state;
    enc_state_t state_nx;
    pack_res_t  pk;
    logic       fire;
    logic       slot_free;
`ifdef INSN_ENC_LI16_EN
    logic [15:0] hi_q;
    logic        load_hi;
`endif

    insn_word_pack u_pack (
        .kind    (req_kind),
        .alu_op  (req_alu_op),
        .use_imm (req_use_imm),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .cond    (req_cond),
        .target  (req_target),
        .addr    (addr),
        .res     (pk)
    );

    // Output register can take a new word this cycle.
    assign slot_free = !w_valid || w_ready;
    assign req_ready = (state == ST_IDLE) && slot_free && !start;
    assign fire      = req_valid && req_ready;

`ifdef INSN_ENC_LI16_EN
    assign load_hi = (state == ST_EMIT_HI) && slot_free && !start;
`endif

    always_comb begin
        state_nx = state;
`ifdef INSN_ENC_LI16_EN
        unique case (state)
            ST_IDLE:
                if (fire && !pk.err && pk.two)
                    state_nx = ST_EMIT_HI;
            ST_EMIT_HI:
                if (load_hi)
                    state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
`endif
        if (start)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid  <= 1'b0;
            w_addr   <= 16'h0000;
            w_data   <= 16'h0000;
            addr     <= RESET_ADDR;
            err      <= 1'b0;
            err_code <= ERR_NONE;
`ifdef INSN_ENC_LI16_EN
            hi_q     <= 16'h0000;
`endif
        end else if (start) begin
            w_valid  <= 1'b0;
            addr     <= start_addr & 16'hFFFE;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (w_valid && w_ready)
                w_valid <= 1'b0;
            if (fire) begin
                if (pk.err) begin
                    // Only the first error since start is kept.
                    if (!err) begin
                        err      <= 1'b1;
                        err_code <= pk.code;
                    end
                end else begin
                    w_valid <= 1'b1;
                    w_addr  <= addr;
                    w_data  <= pk.lo;
                    addr    <= addr + 16'd2;
`ifdef INSN_ENC_LI16_EN
                    hi_q    <= pk.hi;
`endif
                end
            end
`ifdef INSN_ENC_LI16_EN
            if (load_hi) begin
                w_valid <= 1'b1;
                w_addr  <= addr;
                w_data  <= hi_q;
                addr    <= addr + 16'd2;
            end
`endif
        end
    end

endmodule
